// File: rtl/matrix_storage_resp_if.sv
// -----------------------------------------------------------------------------
// matrix_storage_resp_if
// Read/write/clear bundle between the calculator (core, storage mux, top FSM)
// and the matrix storage responder.
//   master : drives i_rd_addr, i_we, i_waddr, i_wdata, i_clear_start
//            and observes the responder outputs.
//   slave  : the storage responder (matrix_storage_resp).
// Signals:
//   i_rd_addr     [ADDR_W]   read address
//   o_rd_data     [DATA_W]   registered read data
//   o_rd_valid    1          registered "word written since last clear/reset"
//   i_we          1          write enable
//   i_waddr       [ADDR_W]   write address
//   i_wdata       [DATA_W]   write data
//   i_clear_start 1          pulse: start wiping the whole store
//   o_busy        1          clear engine active
//   o_clear_done  1          pulse: clear finished
//   o_wr_drop     1          pulse: a write was discarded
//   o_word_count  [ADDR_W+1] number of valid words
// -----------------------------------------------------------------------------
interface matrix_storage_resp_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] i_rd_addr;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_valid;
  logic              i_we;
  logic [ADDR_W-1:0] i_waddr;
  logic [DATA_W-1:0] i_wdata;
  logic              i_clear_start;
  logic              o_busy;
  logic              o_clear_done;
  logic              o_wr_drop;
  logic [ADDR_W:0]   o_word_count;

  modport master (
    output i_rd_addr, i_we, i_waddr, i_wdata, i_clear_start,
    input  o_rd_data, o_rd_valid, o_busy, o_clear_done, o_wr_drop, o_word_count
  );

  modport slave (
    input  i_rd_addr, i_we, i_waddr, i_wdata, i_clear_start,
    output o_rd_data, o_rd_valid, o_busy, o_clear_done, o_wr_drop, o_word_count
  );
endinterface

// File: rtl/matrix_storage_resp.sv
// -----------------------------------------------------------------------------
// matrix_storage_resp
// DEPTH x DATA_W word store answering the calculator storage interface.
//   - 1-cycle registered read with per-word "written" validity
//   - single write port, per-word valid bits and a live valid-word count
//   - sequential clear engine (one word per cycle, DEPTH cycles busy)
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset (valid bits, FSM, outputs;
//            the memory array itself is not reset)
//   bus    : matrix_storage_resp_if.slave (read, write, clear, status)
// Optional build macro:
//   STORAGE_RAW_BYPASS_EN - same-cycle same-address read/write returns the
//   write data (write-first). Undefined: returns pre-write contents.
// -----------------------------------------------------------------------------
module matrix_storage_resp #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  matrix_storage_resp_if.slave bus
);

  localparam int unsigned     IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]  FULL_CNT  = (ADDR_W + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [DATA_W-1:0] r_mem   [DEPTH];
  logic              r_valid [DEPTH];

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_clr_cnt;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_wr_drop;
  logic [ADDR_W:0]   r_word_count;

  logic              w_idle;
  logic              w_wr_in;
  logic              w_rd_in;
  logic              w_wr_ok;
  logic [IDX_W-1:0]  w_widx;
  logic [IDX_W-1:0]  w_ridx;
  logic [DATA_W-1:0] w_rd_data_nxt;
  logic              w_rd_valid_nxt;

  // When the address space is exactly covered every address is in range;
  // skipping the compare avoids a constant-true comparison.
  generate
    if (DEPTH >= (2 ** ADDR_W)) begin : g_full_range
      assign w_wr_in = 1'b1;
      assign w_rd_in = 1'b1;
    end else begin : g_part_range
      assign w_wr_in = ({1'b0, bus.i_waddr}   < FULL_CNT);
      assign w_rd_in = ({1'b0, bus.i_rd_addr} < FULL_CNT);
    end
  endgenerate

  assign w_idle  = (r_state == S_IDLE);
  assign w_wr_ok = w_idle & bus.i_we & w_wr_in;
  assign w_widx  = bus.i_waddr[IDX_W-1:0];
  assign w_ridx  = bus.i_rd_addr[IDX_W-1:0];

  // Next read result: only served in IDLE; invalid or out-of-range -> 0.
  always_comb begin
    w_rd_valid_nxt = w_idle & w_rd_in & r_valid[w_ridx];
    w_rd_data_nxt  = w_rd_valid_nxt ? r_mem[w_ridx] : '0;
`ifdef STORAGE_RAW_BYPASS_EN
    if (w_wr_ok && w_rd_in && (bus.i_waddr == bus.i_rd_addr)) begin
      w_rd_valid_nxt = 1'b1;
      w_rd_data_nxt  = bus.i_wdata;
    end
`endif
  end

  // Memory array: no reset; the clear engine has priority (writes are
  // dropped outside IDLE anyway).
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_ok) begin
      r_mem[w_widx] <= bus.i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
      end
      r_state      <= S_IDLE;
      r_clr_cnt    <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_wr_drop    <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_wr_drop  <= bus.i_we & ~w_wr_ok;
      r_rd_data  <= w_rd_data_nxt;
      r_rd_valid <= w_rd_valid_nxt;

      case (r_state)
        S_IDLE: begin
          if (w_wr_ok) begin
            r_valid[w_widx] <= 1'b1;
            if (!r_valid[w_widx] && (r_word_count != FULL_CNT)) begin
              r_word_count <= r_word_count + (ADDR_W + 1)'(1);
            end
          end
          if (bus.i_clear_start) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
          end
        end
        S_CLEAR: begin
          r_valid[r_clr_cnt] <= 1'b0;
          r_clr_cnt          <= r_clr_cnt + IDX_W'(1);
          if (r_clr_cnt == LAST_IDX) begin
            r_state      <= S_DONE;
            r_word_count <= '0;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_rd_data    = r_rd_data;
  assign bus.o_rd_valid   = r_rd_valid;
  assign bus.o_busy       = (r_state == S_CLEAR);
  assign bus.o_clear_done = (r_state == S_DONE);
  assign bus.o_wr_drop    = r_wr_drop;
  assign bus.o_word_count = r_word_count;

endmodule

// File: tb/tb_matrix_storage_resp.sv
// -----------------------------------------------------------------------------
// tb_matrix_storage_resp
// Self-checking bench for matrix_storage_resp. A full-size instance (256 words)
// covers reset, read/write, read-during-write, clear engine and reset mid-clear;
// a 16-word instance exercises out-of-range addresses. Expected read results
// are queued when the read address is driven and popped one edge later.
// -----------------------------------------------------------------------------
module tb_matrix_storage_resp;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned SDEPTH = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_storage_resp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  matrix_storage_resp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sbus ();

  matrix_storage_resp #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  matrix_storage_resp #(.DEPTH(SDEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut_small (
    .clk(clk), .rst_n(rst_n), .bus(sbus)
  );

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              v;
  } rd_exp_t;

  rd_exp_t     exp_q[$];
  rd_exp_t     e;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.i_rd_addr = 8'h05; bus.i_we = 1'b0; bus.i_waddr = '0; bus.i_wdata = '0; bus.i_clear_start = 1'b0;
    sbus.i_rd_addr = '0;   sbus.i_we = 1'b0; sbus.i_waddr = '0; sbus.i_wdata = '0; sbus.i_clear_start = 1'b0;
    rst_n = 1'b0;
    step(); step();
    n_cmp++;
    if ({bus.o_rd_data, bus.o_rd_valid, bus.o_busy, bus.o_clear_done, bus.o_wr_drop, bus.o_word_count} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got data=%h v=%b busy=%b done=%b drop=%b cnt=%0d, exp all 0",
        bus.o_rd_data, bus.o_rd_valid, bus.o_busy, bus.o_clear_done, bus.o_wr_drop, bus.o_word_count);
    end
    rst_n = 1'b1;
    exp_q.push_back('{d: '0, v: 1'b0});
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (bus.o_rd_data !== e.d || bus.o_rd_valid !== e.v) begin
      n_err++; $display("FAIL reset_read05: got %h/%b exp %h/%b", bus.o_rd_data, bus.o_rd_valid, e.d, e.v);
    end
    n_cmp++;
    if (bus.o_word_count !== 9'd0) begin
      n_err++; $display("FAIL reset_count: got %0d exp 0", bus.o_word_count);
    end
  endtask

  task automatic test_write_read();
    bus.i_we = 1'b1; bus.i_waddr = 8'h10; bus.i_wdata = 32'h0000_002A; bus.i_rd_addr = 8'h05;
    exp_q.push_back('{d: '0, v: 1'b0});
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (bus.o_rd_data !== e.d || bus.o_rd_valid !== e.v) begin
      n_err++; $display("FAIL wr_side_read: got %h/%b exp %h/%b", bus.o_rd_data, bus.o_rd_valid, e.d, e.v);
    end
    bus.i_we = 1'b0; bus.i_rd_addr = 8'h10;
    exp_q.push_back('{d: 32'h2A, v: 1'b1});
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (bus.o_rd_data !== e.d || bus.o_rd_valid !== e.v) begin
      n_err++; $display("FAIL read_10: got %h/%b exp %h/%b", bus.o_rd_data, bus.o_rd_valid, e.d, e.v);
    end
    n_cmp++;
    if (bus.o_word_count !== 9'd1) begin
      n_err++; $display("FAIL count_after_write: got %0d exp 1", bus.o_word_count);
    end
    bus.i_we = 1'b1; bus.i_waddr = 8'h10; bus.i_wdata = 32'h7; bus.i_rd_addr = 8'h11;
    exp_q.push_back('{d: '0, v: 1'b0});
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (bus.o_rd_data !== e.d || bus.o_rd_valid !== e.v) begin
      n_err++; $display("FAIL read_11: got %h/%b exp %h/%b", bus.o_rd_data, bus.o_rd_valid, e.d, e.v);
    end
    n_cmp++;
    if (bus.o_word_count !== 9'd1 || bus.o_wr_drop !== 1'b0) begin
      n_err++; $display("FAIL rewrite_count: got cnt=%0d drop=%b exp cnt=1 drop=0", bus.o_word_count, bus.o_wr_drop);
    end
    bus.i_we = 1'b0; bus.i_rd_addr = 8'h10;
    exp_q.push_back('{d: 32'h7, v: 1'b1});
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (bus.o_rd_data !== e.d || bus.o_rd_valid !== e.v) begin
      n_err++; $display("FAIL reread_10: got %h/%b exp %h/%b", bus.o_rd_data, bus.o_rd_valid, e.d, e.v);
    end
  endtask

  task automatic test_raw();
    bus.i_we = 1'b1; bus.i_waddr = 8'h20; bus.i_wdata = 32'h11; bus.i_rd_addr = 8'h05;
    step();
    bus.i_waddr = 8'h20; bus.i_wdata = 32'h55; bus.i_rd_addr = 8'h20;
`ifdef STORAGE_RAW_BYPASS_EN
    exp_q.push_back('{d: 32'h55, v: 1'b1});
`else
    exp_q.push_back('{d: 32'h11, v: 1'b1});
`endif
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (bus.o_rd_data !== e.d || bus.o_rd_valid !== e.v) begin
      n_err++; $display("FAIL raw_same_cycle: got %h/%b exp %h/%b", bus.o_rd_data, bus.o_rd_valid, e.d, e.v);
    end
    bus.i_we = 1'b0;
    exp_q.push_back('{d: 32'h55, v: 1'b1});
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (bus.o_rd_data !== e.d || bus.o_rd_valid !== e.v) begin
      n_err++; $display("FAIL raw_next_read: got %h/%b exp %h/%b", bus.o_rd_data, bus.o_rd_valid, e.d, e.v);
    end
    n_cmp++;
    if (bus.o_word_count !== 9'd2) begin
      n_err++; $display("FAIL raw_count: got %0d exp 2", bus.o_word_count);
    end
  endtask

  task automatic test_clear();
    int unsigned busy_n, done_n, drops, cyc;
    bus.i_we = 1'b1; bus.i_waddr = 8'h30; bus.i_wdata = 32'hABC; bus.i_rd_addr = 8'h00;
    step();
    // start clear together with a write: the write lands, then gets wiped
    bus.i_clear_start = 1'b1; bus.i_waddr = 8'h50; bus.i_wdata = 32'h77;
    step();
    bus.i_clear_start = 1'b0; bus.i_we = 1'b0;
    n_cmp++;
    if (bus.o_word_count !== 9'd4 || bus.o_busy !== 1'b1) begin
      n_err++; $display("FAIL clear_start_state: got cnt=%0d busy=%b exp cnt=4 busy=1", bus.o_word_count, bus.o_busy);
    end
    busy_n = 0; done_n = 0; drops = 0; cyc = 0;
    while (cyc < 600) begin
      if (bus.o_busy) busy_n++;
      if (bus.o_clear_done) done_n++;
      if (bus.o_wr_drop) drops++;
      if (done_n > 0 && !bus.o_clear_done && !bus.o_busy) break;
      if (cyc == 51) begin
        e = exp_q.pop_front(); n_cmp++;
        if (bus.o_rd_data !== e.d || bus.o_rd_valid !== e.v) begin
          n_err++; $display("FAIL busy_read: got %h/%b exp %h/%b", bus.o_rd_data, bus.o_rd_valid, e.d, e.v);
        end
        n_cmp++;
        if (bus.o_wr_drop !== 1'b1) begin
          n_err++; $display("FAIL busy_wr_drop: got %b exp 1", bus.o_wr_drop);
        end
      end
      if (cyc == 50) begin
        bus.i_we = 1'b1; bus.i_waddr = 8'h40; bus.i_wdata = 32'h99; bus.i_rd_addr = 8'h10;
        exp_q.push_back('{d: '0, v: 1'b0});
      end else begin
        bus.i_we = 1'b0;
      end
      step();
      cyc++;
    end
    n_cmp++;
    if (busy_n != DEPTH || done_n != 1 || drops != 1) begin
      n_err++; $display("FAIL clear_timing: got busy=%0d done=%0d drops=%0d exp busy=%0d done=1 drops=1",
        busy_n, done_n, drops, DEPTH);
    end
    n_cmp++;
    if (bus.o_word_count !== 9'd0) begin
      n_err++; $display("FAIL clear_count: got %0d exp 0", bus.o_word_count);
    end
    bus.i_we = 1'b0; bus.i_rd_addr = 8'h40;
    exp_q.push_back('{d: '0, v: 1'b0});
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (bus.o_rd_data !== e.d || bus.o_rd_valid !== e.v) begin
      n_err++; $display("FAIL dropped_not_kept: got %h/%b exp %h/%b", bus.o_rd_data, bus.o_rd_valid, e.d, e.v);
    end
    bus.i_rd_addr = 8'h50;
    exp_q.push_back('{d: '0, v: 1'b0});
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (bus.o_rd_data !== e.d || bus.o_rd_valid !== e.v) begin
      n_err++; $display("FAIL start_write_wiped: got %h/%b exp %h/%b", bus.o_rd_data, bus.o_rd_valid, e.d, e.v);
    end
  endtask

  task automatic test_clear_retrigger();
    int unsigned busy_n, done_n, cyc;
    bus.i_we = 1'b1; bus.i_waddr = 8'h05; bus.i_wdata = 32'h1;
    step();
    bus.i_we = 1'b0; bus.i_clear_start = 1'b1;
    step();
    busy_n = 0; done_n = 0; cyc = 0;
    while (cyc < 600) begin
      if (bus.o_busy) busy_n++;
      if (bus.o_clear_done) done_n++;
      if (done_n > 0 && !bus.o_clear_done && !bus.o_busy) break;
      bus.i_clear_start = (cyc == 10 || cyc == 255);
      step();
      cyc++;
    end
    bus.i_clear_start = 1'b0;
    n_cmp++;
    if (busy_n != DEPTH || done_n != 1) begin
      n_err++; $display("FAIL retrigger_timing: got busy=%0d done=%0d exp busy=%0d done=1", busy_n, done_n, DEPTH);
    end
    bus.i_rd_addr = 8'h05;
    exp_q.push_back('{d: '0, v: 1'b0});
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (bus.o_rd_data !== e.d || bus.o_rd_valid !== e.v || bus.o_busy !== 1'b0) begin
      n_err++; $display("FAIL retrigger_after: got %h/%b busy=%b exp %h/%b busy=0",
        bus.o_rd_data, bus.o_rd_valid, bus.o_busy, e.d, e.v);
    end
  endtask

  task automatic test_reset_mid_clear();
    int unsigned done_n, busy_n;
    bus.i_we = 1'b1; bus.i_waddr = 8'h60; bus.i_wdata = 32'h3;
    step();
    bus.i_we = 1'b0; bus.i_clear_start = 1'b1;
    step();
    bus.i_clear_start = 1'b0;
    repeat (100) step();
    n_cmp++;
    if (bus.o_busy !== 1'b1) begin
      n_err++; $display("FAIL mid_clear_busy: got %b exp 1", bus.o_busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.o_busy !== 1'b0 || bus.o_clear_done !== 1'b0 || bus.o_word_count !== 9'd0) begin
      n_err++; $display("FAIL async_reset: got busy=%b done=%b cnt=%0d exp 0/0/0",
        bus.o_busy, bus.o_clear_done, bus.o_word_count);
    end
    step();
    rst_n = 1'b1;
    done_n = 0; busy_n = 0;
    repeat (300) begin
      step();
      if (bus.o_clear_done) done_n++;
      if (bus.o_busy) busy_n++;
    end
    n_cmp++;
    if (done_n != 0 || busy_n != 0) begin
      n_err++; $display("FAIL post_reset_quiet: got done=%0d busy=%0d exp 0/0", done_n, busy_n);
    end
    bus.i_rd_addr = 8'h60;
    exp_q.push_back('{d: '0, v: 1'b0});
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (bus.o_rd_data !== e.d || bus.o_rd_valid !== e.v) begin
      n_err++; $display("FAIL post_reset_read60: got %h/%b exp %h/%b", bus.o_rd_data, bus.o_rd_valid, e.d, e.v);
    end
    bus.i_we = 1'b1; bus.i_waddr = 8'h61; bus.i_wdata = 32'hDEAD; bus.i_rd_addr = 8'h62;
    step();
    bus.i_we = 1'b0; bus.i_rd_addr = 8'h61;
    exp_q.push_back('{d: 32'hDEAD, v: 1'b1});
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (bus.o_rd_data !== e.d || bus.o_rd_valid !== e.v || bus.o_word_count !== 9'd1) begin
      n_err++; $display("FAIL post_reset_wr_rd: got %h/%b cnt=%0d exp %h/%b cnt=1",
        bus.o_rd_data, bus.o_rd_valid, bus.o_word_count, e.d, e.v);
    end
  endtask

  task automatic test_range();
    int unsigned busy_n, done_n, cyc;
    sbus.i_we = 1'b1; sbus.i_waddr = 8'd16; sbus.i_wdata = 32'h5A; sbus.i_rd_addr = 8'd0;
    step();
    n_cmp++;
    if (sbus.o_wr_drop !== 1'b1 || sbus.o_word_count !== 9'd0) begin
      n_err++; $display("FAIL oor_write_drop: got drop=%b cnt=%0d exp drop=1 cnt=0", sbus.o_wr_drop, sbus.o_word_count);
    end
    sbus.i_waddr = 8'd15; sbus.i_wdata = 32'hF; sbus.i_rd_addr = 8'd16;
    exp_q.push_back('{d: '0, v: 1'b0});
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (sbus.o_rd_data !== e.d || sbus.o_rd_valid !== e.v) begin
      n_err++; $display("FAIL oor_read16: got %h/%b exp %h/%b", sbus.o_rd_data, sbus.o_rd_valid, e.d, e.v);
    end
    n_cmp++;
    if (sbus.o_wr_drop !== 1'b0 || sbus.o_word_count !== 9'd1) begin
      n_err++; $display("FAIL edge_write15: got drop=%b cnt=%0d exp drop=0 cnt=1", sbus.o_wr_drop, sbus.o_word_count);
    end
    sbus.i_we = 1'b0; sbus.i_rd_addr = 8'd15;
    exp_q.push_back('{d: 32'hF, v: 1'b1});
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (sbus.o_rd_data !== e.d || sbus.o_rd_valid !== e.v) begin
      n_err++; $display("FAIL edge_read15: got %h/%b exp %h/%b", sbus.o_rd_data, sbus.o_rd_valid, e.d, e.v);
    end
    sbus.i_rd_addr = 8'd0;
    exp_q.push_back('{d: '0, v: 1'b0});
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (sbus.o_rd_data !== e.d || sbus.o_rd_valid !== e.v) begin
      n_err++; $display("FAIL alias_read0: got %h/%b exp %h/%b", sbus.o_rd_data, sbus.o_rd_valid, e.d, e.v);
    end
    sbus.i_rd_addr = 8'hFF;
    exp_q.push_back('{d: '0, v: 1'b0});
    step();
    e = exp_q.pop_front(); n_cmp++;
    if (sbus.o_rd_data !== e.d || sbus.o_rd_valid !== e.v) begin
      n_err++; $display("FAIL oor_readFF: got %h/%b exp %h/%b", sbus.o_rd_data, sbus.o_rd_valid, e.d, e.v);
    end
    sbus.i_clear_start = 1'b1;
    step();
    sbus.i_clear_start = 1'b0;
    busy_n = 0; done_n = 0; cyc = 0;
    while (cyc < 60) begin
      if (sbus.o_busy) busy_n++;
      if (sbus.o_clear_done) done_n++;
      if (done_n > 0 && !sbus.o_clear_done && !sbus.o_busy) break;
      step();
      cyc++;
    end
    n_cmp++;
    if (busy_n != SDEPTH || done_n != 1 || sbus.o_word_count !== 9'd0) begin
      n_err++; $display("FAIL small_clear: got busy=%0d done=%0d cnt=%0d exp busy=%0d done=1 cnt=0",
        busy_n, done_n, sbus.o_word_count, SDEPTH);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_raw();
    test_clear();
    test_clear_retrigger();
    test_reset_mid_clear();
    test_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
